// File: rtl/adder.sv
// adder: registered wide adder with optional packed lanes (8/16/32/64) and per-lane carry-out
module adder #(
    parameter int num_bits = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [2:0]            lane_mode,
    input  logic [num_bits-1:0]   dd,
    input  logic [num_bits-1:0]   aa,
    output logic                  out_valid,
    output logic [num_bits-1:0]   sum,
    output logic [num_bits/8-1:0] carry_out
);
    localparam int nb = num_bits / 8;

    logic [num_bits-1:0] sum_d, sum_q;
    logic [nb-1:0]       carry_d, carry_q;
    logic                valid_q;
    logic                c;
    logic [8:0]          s;

    function automatic logic lane_start(input int k, input logic [2:0] m);
        return (k == 0) || (m == 3'd1) || (m == 3'd2 && k % 2 == 0) ||
               (m == 3'd3 && k % 4 == 0) || (m == 3'd4 && k % 8 == 0);
    endfunction

    // byte-slice ripple adder; carry into a byte is killed where a new lane begins
    always_comb begin
        sum_d   = '0;
        carry_d = '0;
        c       = 1'b0;
        s       = '0;
        for (int k = 0; k < nb; k++) begin
            c = lane_start(k, lane_mode) ? 1'b0 : c;
            s = {1'b0, dd[8*k +: 8]} + {1'b0, aa[8*k +: 8]} + {8'd0, c};
            sum_d[8*k +: 8] = s[7:0];
            carry_d[k] = s[8] & ((k == nb - 1) || lane_start(k + 1, lane_mode));
            c = s[8];
        end
    end

    // capture result when operands are valid, otherwise hold; valid flag tracks in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= in_valid ? sum_d : sum_q;
            carry_q <= in_valid ? carry_d : carry_q;
            valid_q <= in_valid;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_adder.sv
// tb_adder: directed self-checking bench for the lane-configurable adder
module tb_adder;
    localparam int W = 512;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [2:0]     lane_mode;
    logic [W-1:0]   dd, aa;
    logic           out_valid;
    logic [W-1:0]   sum;
    logic [W/8-1:0] carry_out;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] ones, d;

    adder #(.num_bits(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .lane_mode(lane_mode),
        .dd(dd), .aa(aa), .out_valid(out_valid), .sum(sum), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
        @(negedge clk);
        lane_mode = m;
        dd        = a;
        aa        = b;
        in_valid  = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ones      = '1;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        lane_mode = 3'd0;
        dd        = 512'd5;
        aa        = 512'd3;
        @(posedge clk);
        #1;
        chk("pre_reset_sum", sum, 512'd8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_sum", sum, '0);
        chk("rst_async_carry", {448'd0, carry_out}, '0);
        chk("rst_async_valid", {511'd0, out_valid}, '0);
        dd = ones;
        aa = ones;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_sum", sum, '0);
        chk("rst_hold_valid", {511'd0, out_valid}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        op(3'd0, 512'h81, 512'd1, 1'b1);
        chk("fw_byte0_sum", sum, 512'h82);
        chk("fw_byte0_valid", {511'd0, out_valid}, 512'd1);

        d = 512'h81 << 304;
        op(3'd0, d, 512'd1, 1'b1);
        chk("fw_byte38_sum", sum, d | 512'd1);

        d = d | (512'hC1 << 504);
        op(3'd0, d, 512'd1, 1'b1);
        chk("fw_byte63_sum", sum, (512'hC1 << 504) | (512'h81 << 304) | 512'd1);
        chk("fw_byte63_carry", {448'd0, carry_out}, '0);

        op(3'd0, ones, 512'd1, 1'b1);
        chk("fw_chain_sum", sum, '0);
        chk("fw_chain_carry", {448'd0, carry_out}, {448'd0, 64'h8000_0000_0000_0000});

        op(3'd1, ones, {64{8'h01}}, 1'b1);
        chk("m8_sum", sum, '0);
        chk("m8_carry", {448'd0, carry_out}, {448'd0, {64{1'b1}}});

        op(3'd4, ones, {8{64'h1}}, 1'b1);
        chk("m64_sum", sum, '0);
        chk("m64_carry", {448'd0, carry_out}, {448'd0, {8{8'h80}}});

        op(3'd4, ones, 512'd1, 1'b1);
        chk("m64_lo_sum", sum, {{448{1'b1}}, 64'h0});
        chk("m64_lo_carry", {448'd0, carry_out}, {448'd0, 64'h80});

        op(3'd2, ones, {32{16'h0001}}, 1'b1);
        chk("b2b1_m16_sum", sum, '0);
        chk("b2b1_m16_carry", {448'd0, carry_out}, {448'd0, {32{2'b10}}});
        chk("b2b1_valid", {511'd0, out_valid}, 512'd1);
        op(3'd3, {16{32'h0000_FFFF}}, {16{32'h0000_0001}}, 1'b1);
        chk("b2b2_m32_sum", sum, {16{32'h0001_0000}});
        chk("b2b2_m32_carry", {448'd0, carry_out}, '0);
        chk("b2b2_valid", {511'd0, out_valid}, 512'd1);
        op(3'd7, ones, 512'd1, 1'b1);
        chk("b2b3_m7_sum", sum, '0);
        chk("b2b3_m7_carry", {448'd0, carry_out}, {448'd0, 64'h8000_0000_0000_0000});
        chk("b2b3_valid", {511'd0, out_valid}, 512'd1);

        op(3'd1, 512'd7, 512'd9, 1'b0);
        chk("idle_valid", {511'd0, out_valid}, '0);
        chk("idle_sum_hold", sum, '0);
        chk("idle_carry_hold", {448'd0, carry_out}, {448'd0, 64'h8000_0000_0000_0000});

        @(negedge clk);
        in_valid = 1'b1;
        lane_mode = 3'd0;
        dd = 512'd1;
        aa = 512'd1;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", sum, '0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_valid", {511'd0, out_valid}, '0);
        op(3'd0, 512'd2, 512'd3, 1'b1);
        chk("postrst_sum", sum, 512'd5);
        chk("postrst_valid2", {511'd0, out_valid}, 512'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
